// File: rtl/s27_scan_test_ctrl_pkg.sv
// Shared definitions for the s27 scan-test sequencer.
// Holds the sequencer state encoding and the default geometry of the
// scan-inserted s27 core. There are no ports.
package s27_scan_test_ctrl_pkg;

    localparam int DEF_CHAIN_LEN = 3;   // scan flops G5, G6, G7
    localparam int DEF_PI_W      = 4;   // primary inputs G0..G3
    localparam int DEF_PO_W      = 1;   // primary output G17
    localparam int DEF_CNT_W     = 16;  // pattern / fail counter width

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_CAPT   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_UNLOAD = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

endpackage

// File: rtl/s27_scan_test_ctrl_if.sv
// Pattern channel into the scan-test sequencer.
// master (pattern source) drives valid + pattern fields and reads ready.
// slave (sequencer) reads valid + pattern fields and drives ready.
// Fields: si (chain load, si[0] shifted first), pi (core inputs),
// exp_po / exp_so (expected capture response), last (final pattern).
interface s27_scan_test_ctrl_if
    import s27_scan_test_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int PI_W      = DEF_PI_W,
    parameter int PO_W      = DEF_PO_W
);
    logic                 valid;
    logic                 ready;
    logic [CHAIN_LEN-1:0] si;
    logic [PI_W-1:0]      pi;
    logic [PO_W-1:0]      exp_po;
    logic [CHAIN_LEN-1:0] exp_so;
    logic                 last;

    modport master (output valid, si, pi, exp_po, exp_so, last, input ready);
    modport slave  (input valid, si, pi, exp_po, exp_so, last, output ready);
endinterface

// File: rtl/s27_scan_test_ctrl_resp_checker.sv
// Response checker for one pattern at a time.
// capt_i    : capture cycle; compares core PO and arms the pending response
// shift_i   : chain shifting (next pattern's load or final unload)
// exp_po_i / core_po_i : expected vs. actual primary outputs at capture
// exp_so_i  : expected captured chain state, bit j leaves the chain in cycle j
// scan_out_i: serial chain output
// verdict_valid_o / verdict_fail_o : one verdict per pattern, on its last
//             unload cycle (combinational so the caller can count it the
//             same edge).
module s27_scan_test_ctrl_resp_checker
    import s27_scan_test_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int PO_W      = DEF_PO_W
) (
    input  logic                 ck_i,
    input  logic                 rst_i,
    input  logic                 capt_i,
    input  logic                 shift_i,
    input  logic [PO_W-1:0]      exp_po_i,
    input  logic [PO_W-1:0]      core_po_i,
    input  logic [CHAIN_LEN-1:0] exp_so_i,
    input  logic                 scan_out_i,
    output logic                 verdict_valid_o,
    output logic                 verdict_fail_o
);
    localparam int             IW       = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [IW-1:0]  LAST_IDX = IW'(CHAIN_LEN - 1);

    logic                 pend_q;
    logic [CHAIN_LEN-1:0] exp_so_q;
    logic [IW-1:0]        idx_q;
    logic                 acc_q;
    logic                 bit_mis_s;

    // exp_so_q shifts in step with the chain, so bit 0 is always the bit due now
    assign bit_mis_s       = scan_out_i ^ exp_so_q[0];
    assign verdict_valid_o = shift_i & pend_q & (idx_q == LAST_IDX);
    assign verdict_fail_o  = acc_q | bit_mis_s;

    // Pending response: armed at capture, consumed bit by bit while shifting
    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q   <= 1'b0;
            exp_so_q <= {CHAIN_LEN{1'b0}};
            idx_q    <= {IW{1'b0}};
            acc_q    <= 1'b0;
        end else if (capt_i) begin
            pend_q   <= 1'b1;
            exp_so_q <= exp_so_i;
            idx_q    <= {IW{1'b0}};
            acc_q    <= |(exp_po_i ^ core_po_i);
        end else if (shift_i && pend_q) begin
            exp_so_q <= exp_so_q >> 1'b1;
            acc_q    <= acc_q | bit_mis_s;
            if (idx_q == LAST_IDX) begin
                pend_q <= 1'b0;
                idx_q  <= {IW{1'b0}};
            end else begin
                idx_q  <= idx_q + IW'(1'b1);
            end
        end
    end
endmodule

// File: rtl/s27_scan_test_ctrl.sv
// Scan-test sequencer for the scan-inserted s27 core.
// ck_i/rst_i      : clock, asynchronous active-high reset
// pat             : pattern channel (valid/ready + pattern fields)
// scan_en_o, scan_in_o, scan_out_i, core_ck_en_o, core_pi_o, core_po_i :
//                   core scan/functional interface
// busy_o, done_o  : run in progress / one-cycle end-of-run pulse
// pat_cnt_o, fail_cnt_o, first_fail_o, fail_seen_o : run statistics
// Each pattern is shifted in while the previous pattern's captured response
// shifts out, then captured for one cycle; the final pattern is unloaded.
module s27_scan_test_ctrl
    import s27_scan_test_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int PI_W      = DEF_PI_W,
    parameter int PO_W      = DEF_PO_W,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 ck_i,
    input  logic                 rst_i,
    s27_scan_test_ctrl_if.slave  pat,
    output logic                 scan_en_o,
    output logic                 scan_in_o,
    input  logic                 scan_out_i,
    output logic                 core_ck_en_o,
    output logic [PI_W-1:0]      core_pi_o,
    input  logic [PO_W-1:0]      core_po_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     pat_cnt_o,
    output logic [CNT_W-1:0]     fail_cnt_o,
    output logic [CNT_W-1:0]     first_fail_o,
    output logic                 fail_seen_o
);
    localparam int               IW       = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam logic [IW-1:0]    LAST_BIT = IW'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    state_e               state_q;
    logic [IW-1:0]        sh_cnt_q;
    logic [CHAIN_LEN-1:0] si_q;
    logic [CHAIN_LEN-1:0] exp_so_q;
    logic [PI_W-1:0]      pi_q;
    logic [PO_W-1:0]      exp_po_q;
    logic                 last_q;
    logic                 scan_en_q, ck_en_q, ready_q, busy_q, done_q;
    logic [CNT_W-1:0]     pat_cnt_q, fail_cnt_q, first_fail_q, pend_idx_q;
    logic                 fail_seen_q;
    logic                 acc_s, first_acc_s, capt_s, shift_s, sh_last_s;
    logic                 verdict_valid_s, verdict_fail_s;

    // ready_q is only ever set in IDLE/CAPT/WAIT, so valid elsewhere is ignored
    assign acc_s       = pat.valid & ready_q;
    assign first_acc_s = acc_s & (state_q == ST_IDLE);
    assign capt_s      = (state_q == ST_CAPT);
    assign shift_s     = (state_q == ST_SHIFT) | (state_q == ST_UNLOAD);
    assign sh_last_s   = (sh_cnt_q == LAST_BIT);

    // Sequencer FSM with registered control outputs
    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            sh_cnt_q  <= {IW{1'b0}};
            scan_en_q <= 1'b0;
            ck_en_q   <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    if (acc_s) begin
                        state_q   <= ST_SHIFT;
                        sh_cnt_q  <= {IW{1'b0}};
                        scan_en_q <= 1'b1;
                        ck_en_q   <= 1'b1;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                    end else begin
                        scan_en_q <= 1'b0;
                        ck_en_q   <= 1'b0;
                        ready_q   <= 1'b1;
                        busy_q    <= (state_q == ST_WAIT);
                    end
                end
                ST_SHIFT: begin
                    if (sh_last_s) begin
                        state_q   <= ST_CAPT;
                        sh_cnt_q  <= {IW{1'b0}};
                        scan_en_q <= 1'b0;
                        ck_en_q   <= 1'b1;
                        ready_q   <= ~last_q;
                    end else begin
                        sh_cnt_q  <= sh_cnt_q + IW'(1'b1);
                    end
                end
                ST_CAPT: begin
                    if (last_q) begin
                        state_q   <= ST_UNLOAD;
                        scan_en_q <= 1'b1;
                        ck_en_q   <= 1'b1;
                        ready_q   <= 1'b0;
                    end else if (acc_s) begin
                        state_q   <= ST_SHIFT;
                        scan_en_q <= 1'b1;
                        ck_en_q   <= 1'b1;
                        ready_q   <= 1'b0;
                    end else begin
                        // core clock off so the chain keeps the captured state
                        state_q   <= ST_WAIT;
                        scan_en_q <= 1'b0;
                        ck_en_q   <= 1'b0;
                        ready_q   <= 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (sh_last_s) begin
                        state_q   <= ST_FIN;
                        sh_cnt_q  <= {IW{1'b0}};
                        scan_en_q <= 1'b0;
                        ck_en_q   <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        sh_cnt_q  <= sh_cnt_q + IW'(1'b1);
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    sh_cnt_q  <= {IW{1'b0}};
                    scan_en_q <= 1'b0;
                    ck_en_q   <= 1'b0;
                    ready_q   <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    // Pattern latch; si_q drains towards bit 0 so scan_in is si[j] in shift
    // cycle j and zero-filled by the time the unload starts
    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            si_q     <= {CHAIN_LEN{1'b0}};
            exp_so_q <= {CHAIN_LEN{1'b0}};
            pi_q     <= {PI_W{1'b0}};
            exp_po_q <= {PO_W{1'b0}};
            last_q   <= 1'b0;
        end else if (acc_s) begin
            si_q     <= pat.si;
            exp_so_q <= pat.exp_so;
            pi_q     <= pat.pi;
            exp_po_q <= pat.exp_po;
            last_q   <= pat.last;
        end else if (state_q == ST_SHIFT) begin
            si_q     <= si_q >> 1'b1;
        end
    end

    // Run statistics, cleared by the first accept of a run
    always_ff @(posedge ck_i or posedge rst_i) begin
        if (rst_i) begin
            pat_cnt_q    <= {CNT_W{1'b0}};
            fail_cnt_q   <= {CNT_W{1'b0}};
            first_fail_q <= {CNT_W{1'b0}};
            pend_idx_q   <= {CNT_W{1'b0}};
            fail_seen_q  <= 1'b0;
        end else if (first_acc_s) begin
            pat_cnt_q    <= CNT_ONE;
            fail_cnt_q   <= {CNT_W{1'b0}};
            first_fail_q <= {CNT_W{1'b0}};
            pend_idx_q   <= {CNT_W{1'b0}};
            fail_seen_q  <= 1'b0;
        end else begin
            if (acc_s && (pat_cnt_q != CNT_MAX)) begin
                pat_cnt_q <= pat_cnt_q + CNT_ONE;
            end
            // pattern being captured is number pat_cnt_q, index pat_cnt_q-1
            if (capt_s) begin
                pend_idx_q <= pat_cnt_q - CNT_ONE;
            end
            if (verdict_valid_s && verdict_fail_s) begin
                if (fail_cnt_q != CNT_MAX) begin
                    fail_cnt_q <= fail_cnt_q + CNT_ONE;
                end
                if (!fail_seen_q) begin
                    fail_seen_q  <= 1'b1;
                    first_fail_q <= pend_idx_q;
                end
            end
        end
    end

    s27_scan_test_ctrl_resp_checker #(
        .CHAIN_LEN (CHAIN_LEN),
        .PO_W      (PO_W)
    ) u_chk (
        .ck_i            (ck_i),
        .rst_i           (rst_i),
        .capt_i          (capt_s),
        .shift_i         (shift_s),
        .exp_po_i        (exp_po_q),
        .core_po_i       (core_po_i),
        .exp_so_i        (exp_so_q),
        .scan_out_i      (scan_out_i),
        .verdict_valid_o (verdict_valid_s),
        .verdict_fail_o  (verdict_fail_s)
    );

    assign pat.ready    = ready_q;
    assign scan_en_o    = scan_en_q;
    assign scan_in_o    = si_q[0];
    assign core_ck_en_o = ck_en_q;
    assign core_pi_o    = pi_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign pat_cnt_o    = pat_cnt_q;
    assign fail_cnt_o   = fail_cnt_q;
    assign first_fail_o = first_fail_q;
    assign fail_seen_o  = fail_seen_q;
endmodule

// File: tb/tb_s27_scan_test_ctrl.sv
// Directed bench: dut drives a behavioural s27 core; dut2 (2-bit counters)
// faces a core whose PO is stuck at 0 to exercise counter saturation.
module tb_s27_scan_test_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT 1 with s27 core model ----------------
    s27_scan_test_ctrl_if #(.CHAIN_LEN(3), .PI_W(4), .PO_W(1)) u_if ();
    logic        scan_en, scan_in, scan_out, ck_en, busy, done, fail_seen;
    logic [3:0]  core_pi;
    logic [0:0]  core_po;
    logic [15:0] pat_cnt, fail_cnt, first_fail;
    logic [2:0]  ff_q = 3'b000;   // ff_q[0]=G5 (chain end), [1]=G6, [2]=G7

    s27_scan_test_ctrl #(.CHAIN_LEN(3), .PI_W(4), .PO_W(1), .CNT_W(16)) u_dut (
        .ck_i(clk), .rst_i(rst), .pat(u_if),
        .scan_en_o(scan_en), .scan_in_o(scan_in), .scan_out_i(scan_out),
        .core_ck_en_o(ck_en), .core_pi_o(core_pi), .core_po_i(core_po),
        .busy_o(busy), .done_o(done), .pat_cnt_o(pat_cnt), .fail_cnt_o(fail_cnt),
        .first_fail_o(first_fail), .fail_seen_o(fail_seen)
    );

    // s27 netlist: returns {next G7, next G6, next G5, G17}
    function automatic logic [3:0] s27_eval(input logic [3:0] pi, input logic [2:0] s);
        logic g0, g1, g2, g3, g5, g6, g7;
        logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
        {g3, g2, g1, g0} = pi;
        {g7, g6, g5}     = s;
        g14 = ~g0;
        g12 = ~(g1 | g7);
        g8  = g14 & g6;
        g15 = g12 | g8;
        g16 = g3 | g8;
        g9  = ~(g16 & g15);
        g11 = ~(g5 | g9);
        g10 = ~(g14 | g11);
        g13 = ~(g2 | g12);
        return {g13, g11, g10, ~g11};
    endfunction

    logic [3:0] core_eval;
    assign core_eval = s27_eval(core_pi, ff_q);
    assign core_po   = core_eval[0];
    assign scan_out  = ff_q[0];

    always @(posedge clk) begin
        if (ck_en) ff_q <= scan_en ? {scan_in, ff_q[2:1]} : core_eval[3:1];
    end

    // ---------------- DUT 2: saturation, PO stuck at 0 ----------------
    s27_scan_test_ctrl_if #(.CHAIN_LEN(3), .PI_W(4), .PO_W(1)) u_if2 ();
    logic        scan_en2, scan_in2, ck_en2, busy2, done2, fail_seen2;
    logic [3:0]  core_pi2;
    logic [0:0]  core_po2 = 1'b0;
    logic        scan_out2 = 1'b0;
    logic [1:0]  pat_cnt2, fail_cnt2, first_fail2;

    s27_scan_test_ctrl #(.CHAIN_LEN(3), .PI_W(4), .PO_W(1), .CNT_W(2)) u_dut2 (
        .ck_i(clk), .rst_i(rst), .pat(u_if2),
        .scan_en_o(scan_en2), .scan_in_o(scan_in2), .scan_out_i(scan_out2),
        .core_ck_en_o(ck_en2), .core_pi_o(core_pi2), .core_po_i(core_po2),
        .busy_o(busy2), .done_o(done2), .pat_cnt_o(pat_cnt2), .fail_cnt_o(fail_cnt2),
        .first_fail_o(first_fail2), .fail_seen_o(fail_seen2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one pattern to DUT 1; expected response derived from the s27 model,
    // optionally corrupted. Returns the cycle count right after the accepting edge.
    task automatic send(input logic [2:0] si, input logic [3:0] pi, input logic fpo,
                        input logic [2:0] fso, input logic last, output int acc_cyc);
        logic [3:0] e;
        e = s27_eval(pi, si);
        @(negedge clk);
        u_if.si = si; u_if.pi = pi; u_if.exp_po = e[0] ^ fpo;
        u_if.exp_so = e[3:1] ^ fso; u_if.last = last; u_if.valid = 1'b1;
        for (int k = 0; k < 60 && !u_if.ready; k++) @(negedge clk);
        chk("accept_ready", {31'd0, u_if.ready}, 32'd1);
        @(posedge clk);
        #1 u_if.valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic send2(input logic last);
        @(negedge clk);
        u_if2.si = 3'b110; u_if2.pi = 4'b0101; u_if2.exp_po = 1'b1;
        u_if2.exp_so = 3'b000; u_if2.last = last; u_if2.valid = 1'b1;
        for (int k = 0; k < 60 && !u_if2.ready; k++) @(negedge clk);
        chk("accept_ready2", {31'd0, u_if2.ready}, 32'd1);
        @(posedge clk);
        #1 u_if2.valid = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output int busy_n, output int done_n,
                               output int done_at);
        busy_n = 0; done_n = 0; done_at = -1000;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = cyc;
            end
        end
    endtask

    initial begin
        int c0, c1, bn, dn, da;
        logic [2:0] snap;
        logic [3:0] e;
        u_if.valid = 1'b0; u_if.si = 3'b000; u_if.pi = 4'b0000;
        u_if.exp_po = 1'b0; u_if.exp_so = 3'b000; u_if.last = 1'b0;
        u_if2.valid = 1'b0; u_if2.si = 3'b000; u_if2.pi = 4'b0000;
        u_if2.exp_po = 1'b0; u_if2.exp_so = 3'b000; u_if2.last = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, u_if.ready}, 32'd0);
        chk("rst_scan_en", {31'd0, scan_en}, 32'd0);
        chk("rst_ck_en", {31'd0, ck_en}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pat_cnt", {16'd0, pat_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, u_if.ready}, 32'd1);

        // 1: single LAST pattern, matching core
        send(3'b101, 4'b0010, 1'b0, 3'b000, 1'b1, c0);
        chk("t1_scan_en", {31'd0, scan_en}, 32'd1);
        chk("t1_ck_en", {31'd0, ck_en}, 32'd1);
        chk("t1_scan_in", {31'd0, scan_in}, 32'd1);
        chk("t1_ready", {31'd0, u_if.ready}, 32'd0);
        run_to_done(20, bn, dn, da);
        chk("t1_done_lat", da - c0, 32'd7);
        chk("t1_done_n", dn, 32'd1);
        chk("t1_busy_n", bn, 32'd8);
        chk("t1_pat_cnt", {16'd0, pat_cnt}, 32'd1);
        chk("t1_fail_cnt", {16'd0, fail_cnt}, 32'd0);
        chk("t1_fail_seen", {31'd0, fail_seen}, 32'd0);

        // 2: three back-to-back, pattern 1 EXP_SO bit2 flipped
        send(3'b011, 4'b1001, 1'b0, 3'b000, 1'b0, c0);
        send(3'b110, 4'b0100, 1'b0, 3'b100, 1'b0, c1);
        chk("t2_b2b_gap", c1 - c0, 32'd4);
        send(3'b000, 4'b1111, 1'b0, 3'b000, 1'b1, c1);
        run_to_done(20, bn, dn, da);
        chk("t2_done_lat", da - c0, 32'd15);
        chk("t2_done_n", dn, 32'd1);
        chk("t2_busy_tail", bn, 32'd8);
        chk("t2_fail_cnt", {16'd0, fail_cnt}, 32'd1);
        chk("t2_first_fail", {16'd0, first_fail}, 32'd1);
        chk("t2_fail_seen", {31'd0, fail_seen}, 32'd1);
        chk("t2_pat_cnt", {16'd0, pat_cnt}, 32'd3);

        // 3: stall after capture, chain must hold
        send(3'b111, 4'b0001, 1'b0, 3'b000, 1'b0, c0);
        repeat (5) @(negedge clk);
        e = s27_eval(4'b0001, 3'b111);
        snap = ff_q;
        chk("t3_wait_ck_en", {31'd0, ck_en}, 32'd0);
        chk("t3_wait_ready", {31'd0, u_if.ready}, 32'd1);
        chk("t3_wait_busy", {31'd0, busy}, 32'd1);
        chk("t3_captured", {29'd0, snap}, {29'd0, e[3:1]});
        repeat (4) @(negedge clk);
        chk("t3_chain_hold", {29'd0, ff_q}, {29'd0, snap});
        chk("t3_hold_ck_en", {31'd0, ck_en}, 32'd0);
        send(3'b001, 4'b1010, 1'b0, 3'b000, 1'b1, c1);
        run_to_done(20, bn, dn, da);
        chk("t3_fail_cnt", {16'd0, fail_cnt}, 32'd0);
        chk("t3_pat_cnt", {16'd0, pat_cnt}, 32'd2);
        chk("t3_done_n", dn, 32'd1);

        // 4: PO-only mismatch, then PO+SO mismatch; each counted once
        send(3'b010, 4'b0110, 1'b1, 3'b000, 1'b0, c0);
        send(3'b001, 4'b1000, 1'b1, 3'b011, 1'b1, c1);
        run_to_done(20, bn, dn, da);
        chk("t4_fail_cnt", {16'd0, fail_cnt}, 32'd2);
        chk("t4_first_fail", {16'd0, first_fail}, 32'd0);
        chk("t4_fail_seen", {31'd0, fail_seen}, 32'd1);
        chk("t4_pat_cnt", {16'd0, pat_cnt}, 32'd2);

        // 5: reset in the middle of a shift
        send(3'b100, 4'b0011, 1'b1, 3'b000, 1'b0, c0);
        send(3'b011, 4'b0111, 1'b0, 3'b000, 1'b0, c1);
        send(3'b101, 4'b1100, 1'b0, 3'b000, 1'b0, c1);
        chk("t5_pre_fail_cnt", {16'd0, fail_cnt}, 32'd1);
        chk("t5_pre_scan_en", {31'd0, scan_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_scan_en", {31'd0, scan_en}, 32'd0);
        chk("t5_rst_ck_en", {31'd0, ck_en}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_pat_cnt", {16'd0, pat_cnt}, 32'd0);
        chk("t5_rst_fail_cnt", {16'd0, fail_cnt}, 32'd0);
        chk("t5_rst_fail_seen", {31'd0, fail_seen}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(3'b101, 4'b0010, 1'b0, 3'b000, 1'b1, c0);
        run_to_done(20, bn, dn, da);
        chk("t5_done_lat", da - c0, 32'd7);
        chk("t5_pat_cnt", {16'd0, pat_cnt}, 32'd1);
        chk("t5_fail_cnt", {16'd0, fail_cnt}, 32'd0);

        // 6: saturation with 2-bit counters, 5 failing patterns
        for (int i = 0; i < 5; i++) send2(i == 4);
        dn = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done2) dn++;
        end
        chk("t6_done_n", dn, 32'd1);
        chk("t6_fail_cnt", {30'd0, fail_cnt2}, 32'd3);
        chk("t6_pat_cnt", {30'd0, pat_cnt2}, 32'd3);
        chk("t6_first_fail", {30'd0, first_fail2}, 32'd0);
        chk("t6_fail_seen", {31'd0, fail_seen2}, 32'd1);
        chk("t6_busy", {31'd0, busy2}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
